// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0 -- presented to decode when no real instruction is available
  localparam logic [XLEN-1:0] NOP_INSTR_WORD = 32'h0000_0000;

  // One fetched instruction together with its return/link address
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus_4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the fetch queue.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_f,
  input  logic             stall_d,
  input  logic             flush,
  output logic             push,
  output logic             fetch_enable,
  output logic             valid_d,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  // Qualify push/pop from registered occupancy and compute next pointer/count state
  always_comb begin
    fetch_enable = (count_q != CNT_W'(DEPTH)) && !rst;
    valid_d      = (count_q != '0) && !rst;
    push         = valid_f && fetch_enable && !flush;
    pop          = valid_d && !stall_d && !flush;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; replaces the IF/ID register.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [XLEN-1:0]              instr_f,
  input  logic [XLEN-1:0]              pc_plus_4_f,
  input  logic                         valid_f,
  output logic                         fetch_enable,
  input  logic                         stall_d,
  input  logic                         flush,
  output logic [XLEN-1:0]              instr_d,
  output logic [XLEN-1:0]              pc_plus_4_d,
  output logic                         valid_d,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     storage_q [DEPTH];
  fetch_entry_t     storage_d [DEPTH];
  fetch_entry_t     head;
  logic             push;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  fifo_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst          (rst),
    .valid_f      (valid_f),
    .stall_d      (stall_d),
    .flush        (flush),
    .push         (push),
    .fetch_enable (fetch_enable),
    .valid_d      (valid_d),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count)
  );

  // Write the incoming fetch entry into the slot at the write pointer
  always_comb begin
    storage_d = storage_q;
    if (push) begin
      storage_d[wr_ptr] = '{instr: instr_f, pc_plus_4: pc_plus_4_f};
    end
  end

  // Storage needs no reset: slots are only ever read while they hold a valid entry
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

  // Present the head entry, substituting a NOP bubble whenever nothing valid is queued
  always_comb begin
    head        = storage_q[rd_ptr];
    instr_d     = valid_d ? head.instr     : NOP_INSTR;
    pc_plus_4_d = valid_d ? head.pc_plus_4 : '0;
  end

endmodule
